alu_result_queue: RTL and testbench
===================================

Name: alu_result_queue

Overview:
- Parametrised elastic buffer between the ALU output and the downstream consumer (CDB arbiter / ROB writeback).
- Replaces the single-entry passthrough register with a DEPTH-entry circular FIFO, plus occupancy/almost-full status and a flush for branch mispredicts.
- Input side uses valid/ready; output side uses valid/yumi.

Parameters:
- WIDTH, 32, payload bits per entry.
- DEPTH, 4, number of entries; legal range 1..64, any integer (not restricted to powers of two).
- AFULL_THRESH, DEPTH-1, occupancy at or above which almost_full_o asserts; legal range 1..DEPTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; empties the queue.
- valid_i  in  1  input payload valid.
- ready_o  out  1  queue can accept an entry this cycle.
- data_i  in  WIDTH  input payload.
- valid_o  out  1  head entry valid.
- yumi_i  in  1  consumer takes the head entry this cycle.
- data_o  out  WIDTH  head payload.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- almost_full_o  out  1  count_o >= AFULL_THRESH.

Behaviour:
- Reset (reset_n_i=0, asynchronous, any cycle including mid-transfer):
  - rd_ptr, wr_ptr and count clear to 0.
  - Outputs: valid_o=0, data_o=0, count_o=0, ready_o=1, almost_full_o=0.
  - Storage array is not reset.
- Enqueue happens when valid_i && ready_o && !flush_i: mem[wr_ptr] <= data_i; wr_ptr advances.
- Dequeue happens when yumi_i && valid_o && !flush_i: rd_ptr advances.
- ready_o = (count < DEPTH). It depends only on registered state, never on yumi_i, so there is no combinational ready/yumi path. A full queue therefore rejects input even in a cycle when the consumer dequeues.
- valid_o = (count != 0), subject to the bypass feature below.
- data_o = mem[rd_ptr] when valid_o=1, else forced to 0.
- Pointer wrap: a pointer at DEPTH-1 advances to 0 (explicit compare, not modulo-2^n).
- Count update:
  - enqueue only: +1.
  - dequeue only: -1.
  - both in the same cycle: unchanged; both pointers advance.
- Flush has highest priority after reset:
  - pointers and count go to 0 on the next edge.
  - any valid_i or yumi_i in the flush cycle is discarded.
  - valid_o=0 from the cycle after the flush.
- yumi_i while valid_o=0 is illegal. The RTL ignores it; the bench flags it with an assertion.
- valid_i may drop without a handshake (no stability requirement on the producer side).
- Latency without bypass: an entry enqueued at edge N is visible on valid_o/data_o after edge N (the next cycle).
- Full boundary: count==DEPTH gives ready_o=0; a valid_i that cycle is not accepted and the producer must hold it.
- Empty boundary: count==0 gives valid_o=0 (unless bypass applies).

Optional Feature:
- Macro: ALU_Q_BYPASS_EN.
- When defined, empty-queue bypass:
  - If count==0, valid_i=1 and flush_i=0, then valid_o=1 and data_o=data_i combinationally (zero latency).
  - If yumi_i=1 in that same cycle, the entry is consumed and not written; count stays 0.
  - Otherwise it is written normally and count becomes 1.
  - ready_o is unaffected.
- When undefined: 1-cycle minimum latency as above, and no combinational path from valid_i/data_i to outputs.

Decomposition:
- Package alu_q_pkg holds:
  - ALU_Q_WIDTH_DEFAULT=32 and ALU_Q_DEPTH_DEFAULT=4 localparams.
  - function ptr_next(ptr, depth) implementing the wrap rule.
  - typedef for the occupancy count width helper.
- One sub-module: alu_q_ptr, a parametrised wrap-around pointer register with an advance input, async active-low reset and a synchronous clear. It is instantiated twice (rd and wr).

Test Plan:
- Reset/idle: hold reset_n_i=0 for 3 cycles, then release -> valid_o=0, ready_o=1, count_o=0, data_o=0.
- Fill/drain (DEPTH=4): enqueue 0x11,0x22,0x33,0x44 with yumi_i=0 -> count_o=4, ready_o=0, almost_full_o=1 from count 3. Then drain with yumi_i=1 -> data_o sequence 0x11..0x44, valid_o=0 after the 4th.
- Simultaneous enqueue/dequeue at count=2 for 10 cycles with incrementing data -> count_o stays 2, in-order output, pointers wrap past index 3 with no loss.
- Full with yumi: count=4, valid_i=1 data 0x55, yumi_i=1 -> head dequeued, 0x55 not accepted, count_o=3 next cycle.
- Flush: count=3, assert flush_i together with valid_i=1 and yumi_i=1 -> next cycle count_o=0, valid_o=0, nothing enqueued or dequeued. Async reset asserted mid-stream at count=2 -> immediate valid_o=0, count_o=0.
- ALU_Q_BYPASS_EN defined: empty, valid_i=1 data 0xAB, yumi_i=1 -> same-cycle valid_o=1, data_o=0xAB, count_o stays 0. Undefined -> valid_o=0 that cycle and 0xAB appears the next cycle.

Source files
------------

// File: rtl/alu_q_pkg.sv
// alu_q_pkg: shared constants and helpers for the ALU result queue.
//   - Default payload width and depth.
//   - ptr_next(): wrap-around pointer increment for arbitrary (non power-of-two) depths.
//   - cnt_width() / alu_q_cnt_t: occupancy counter width helpers.
package alu_q_pkg;

   localparam int unsigned ALU_Q_WIDTH_DEFAULT = 32;
   localparam int unsigned ALU_Q_DEPTH_DEFAULT = 4;

   // Occupancy must represent 0..DEPTH inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef logic [$clog2(ALU_Q_DEPTH_DEFAULT + 1)-1:0] alu_q_cnt_t;

   // Explicit compare against the last index so any depth wraps correctly.
   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/alu_q_ptr.sv
// alu_q_ptr: wrap-around index register for the ALU result queue.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset (pointer -> 0)
//   clear_i    synchronous clear (pointer -> 0), wins over adv_i
//   adv_i      advance the pointer by one, wrapping DEPTH-1 -> 0
//   ptr_o      current pointer value
module alu_q_ptr
   import alu_q_pkg::*;
#(
   parameter int unsigned DEPTH = ALU_Q_DEPTH_DEFAULT,
   parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             clear_i,
   input  logic             adv_i,
   output logic [PTR_W-1:0] ptr_o
);

   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clear_i) begin
         ptr_d = '0;
      end else if (adv_i) begin
         ptr_d = PTR_W'(ptr_next(32'(ptr_q), DEPTH));
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: DEPTH-entry circular FIFO between the ALU and its consumer.
// Input side is valid/ready, output side is valid/yumi. ready_o depends only on
// registered occupancy, so a full queue refuses input even while being drained.
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   flush_i                  synchronous flush; discards any same-cycle enq/deq
//   valid_i, ready_o, data_i producer handshake and payload
//   valid_o, yumi_i, data_o  consumer handshake and head payload (0 when invalid)
//   count_o                  occupancy
//   almost_full_o            count_o >= AFULL_THRESH
// Build option: define ALU_Q_BYPASS_EN for zero-latency bypass when the queue is
// empty (data_i forwarded to data_o; consumed directly if yumi_i is high).
module alu_result_queue
   import alu_q_pkg::*;
#(
   parameter int unsigned WIDTH        = ALU_Q_WIDTH_DEFAULT,
   parameter int unsigned DEPTH        = ALU_Q_DEPTH_DEFAULT,
   parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         flush_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [WIDTH-1:0]             data_i,
   output logic                         valid_o,
   input  logic                         yumi_i,
   output logic [WIDTH-1:0]             data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         almost_full_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CntW-1:0]  count_q, count_d;
   logic [PtrW-1:0]  rd_ptr, wr_ptr;
   logic             not_empty;
   logic             bypass;
   logic             enq, deq;

   assign not_empty = (count_q != '0);
   assign ready_o   = (count_q < CntW'(DEPTH));

`ifdef ALU_Q_BYPASS_EN
   assign bypass = !not_empty && valid_i && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry taken by the consumer in the same cycle is never stored.
   assign enq = valid_i && ready_o && !flush_i && !(bypass && yumi_i);
   assign deq = yumi_i && not_empty && !flush_i;

   always_comb begin
      valid_o = not_empty || bypass;
      data_o  = '0;
      if (not_empty) begin
         data_o = mem_q[rd_ptr];
      end else if (bypass) begin
         data_o = data_i;
      end
   end

   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (enq && !deq) begin
         count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage is intentionally not reset; valid_o gates its visibility.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wr_ptr] <= data_i;
      end
   end

   alu_q_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PtrW)
   ) u_wr_ptr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (flush_i),
      .adv_i     (enq),
      .ptr_o     (wr_ptr)
   );

   alu_q_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PtrW)
   ) u_rd_ptr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (flush_i),
      .adv_i     (deq),
      .ptr_o     (rd_ptr)
   );

   assign count_o       = count_q;
   assign almost_full_o = (count_q >= CntW'(AFULL_THRESH));

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue (DEPTH=4, WIDTH=32). Expected head values
// are queued when the stimulus issues an entry; a negedge monitor pops and
// compares whenever the consumer takes the head. Status outputs are checked
// against hand-computed constants from the stimulus thread.
module tb_alu_result_queue;

   logic        clk;
   logic        rst_n;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_i;
   logic        valid_o;
   logic        yumi_i;
   logic [31:0] data_o;
   logic [2:0]  count_o;
   logic        almost_full_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   alu_result_queue #(
      .WIDTH        (32),
      .DEPTH        (4),
      .AFULL_THRESH (3)
   ) dut (
      .clk_i         (clk),
      .reset_n_i     (rst_n),
      .flush_i       (flush_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .data_i        (data_i),
      .valid_o       (valid_o),
      .yumi_i        (yumi_i),
      .data_o        (data_o),
      .count_o       (count_o),
      .almost_full_o (almost_full_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: a transfer happens at the next edge when valid_o && yumi_i.
   always @(negedge clk) begin
      if (rst_n && !flush_i && valid_o && yumi_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=%h expected=none", data_o);
         end else begin
            chk("sb_data", data_o, exp_q.pop_front());
         end
      end
   end

   // Consumer must never take from an empty output.
   always @(negedge clk) begin
      if (rst_n) begin
         assert (!(yumi_i && !valid_o)) else $error("yumi_i asserted while valid_o=0");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] vals [4];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

      rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; yumi_i = 1'b0; data_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      chk("rst_count", 32'(count_o), 0);
      chk("rst_data", data_o, 0);
      chk("rst_afull", 32'(almost_full_o), 0);
      step();

      // Fill to full.
      for (int i = 0; i < 4; i++) begin
         valid_i = 1'b1; data_i = vals[i];
         exp_q.push_back(vals[i]);
         @(negedge clk);
         chk("fill_count", 32'(count_o), 32'(i));
         chk("fill_afull", 32'(almost_full_o), (i >= 3) ? 1 : 0);
         step();
      end
      valid_i = 1'b0; yumi_i = 1'b1;
      @(negedge clk);
      chk("full_count", 32'(count_o), 4);
      chk("full_ready", 32'(ready_o), 0);
      chk("full_afull", 32'(almost_full_o), 1);
      repeat (4) step();
      yumi_i = 1'b0;
      @(negedge clk);
      chk("drain_valid", 32'(valid_o), 0);
      chk("drain_count", 32'(count_o), 0);
      chk("drain_data", data_o, 0);
      step();

      // Concurrent enqueue/dequeue at count 2; pointers wrap several times.
      for (int i = 0; i < 2; i++) begin
         valid_i = 1'b1; data_i = 32'h100 + 32'(i);
         exp_q.push_back(data_i);
         step();
      end
      yumi_i = 1'b1;
      for (int i = 2; i < 12; i++) begin
         data_i = 32'h100 + 32'(i);
         exp_q.push_back(data_i);
         @(negedge clk);
         chk("steady_count", 32'(count_o), 2);
         step();
      end
      valid_i = 1'b0;
      repeat (2) step();
      yumi_i = 1'b0;
      @(negedge clk);
      chk("steady_empty", 32'(count_o), 0);
      step();

      // Full queue with yumi: head leaves, 0x55 rejected.
      for (int i = 0; i < 4; i++) begin
         valid_i = 1'b1; data_i = 32'h61 + 32'(i);
         exp_q.push_back(data_i);
         step();
      end
      data_i = 32'h55; yumi_i = 1'b1;
      @(negedge clk);
      chk("fy_ready", 32'(ready_o), 0);
      step();
      valid_i = 1'b0; yumi_i = 1'b0;
      @(negedge clk);
      chk("fy_count", 32'(count_o), 3);
      chk("fy_head", data_o, 32'h62);

      // Flush at count 3 with valid_i and yumi_i also high.
      step();
      flush_i = 1'b1; valid_i = 1'b1; yumi_i = 1'b1; data_i = 32'h77;
      step();
      flush_i = 1'b0; valid_i = 1'b0; yumi_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("flush_count", 32'(count_o), 0);
      chk("flush_valid", 32'(valid_o), 0);
      step();
      @(negedge clk);
      chk("flush_noenq", 32'(count_o), 0);
      step();

      // Asynchronous reset mid-stream at count 2.
      for (int i = 0; i < 2; i++) begin
         valid_i = 1'b1; data_i = 32'h81 + 32'(i);
         step();
      end
      valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("areset_valid", 32'(valid_o), 0);
      chk("areset_count", 32'(count_o), 0);
      chk("areset_ready", 32'(ready_o), 1);
      step();
      rst_n = 1'b1;
      step();

      // Empty-queue bypass behaviour.
      valid_i = 1'b1; data_i = 32'hAB;
      exp_q.push_back(32'hAB);
`ifdef ALU_Q_BYPASS_EN
      yumi_i = 1'b1;
      @(negedge clk);
      chk("byp_valid", 32'(valid_o), 1);
      chk("byp_data", data_o, 32'hAB);
      chk("byp_count", 32'(count_o), 0);
      step();
      valid_i = 1'b0; yumi_i = 1'b0;
      @(negedge clk);
      chk("byp_after_count", 32'(count_o), 0);
      chk("byp_after_valid", 32'(valid_o), 0);
`else
      @(negedge clk);
      chk("nobyp_valid", 32'(valid_o), 0);
      chk("nobyp_data", data_o, 0);
      step();
      valid_i = 1'b0;
      @(negedge clk);
      chk("nobyp_next_valid", 32'(valid_o), 1);
      chk("nobyp_next_data", data_o, 32'hAB);
      chk("nobyp_next_count", 32'(count_o), 1);
      step();
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
      @(negedge clk);
      chk("nobyp_drain_count", 32'(count_o), 0);
`endif
      step();
      chk("sb_leftover", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
